// File: rtl/test_phase_sequencer.sv
// Run sequencer on virclk: DUT reset, settle, N measurement windows,
// checker handshake per window, sticky finish/fail status.
module test_phase_sequencer #(
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int MEAS_CYCLES   = 32,
  parameter int N_WINDOWS     = 4,
  parameter int ACK_TIMEOUT   = 64,
  parameter int CW            = 16
) (
  input  logic          virclk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          chk_ack,
  input  logic          chk_pass,
  output logic          dut_rst,
  output logic          meas_en,
  output logic          win_start,
  output logic [7:0]    win_idx,
  output logic          chk_req,
  output logic          busy,
  output logic          finish,
  output logic          fail,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_SETTLE,
    S_MEAS,
    S_WAIT,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [31:0] RST_LD  = 32'(RST_CYCLES - 1);
  localparam logic [31:0] SET_LD  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] MEAS_LD = 32'(MEAS_CYCLES - 1);
  localparam logic [31:0] ACK_LD  = 32'(ACK_TIMEOUT - 1);
  localparam logic [7:0]  LAST_W  = 8'(N_WINDOWS - 1);

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [7:0]    win_q, win_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          active;
  logic          expired;

  assign active  = state_q inside {S_RESET, S_SETTLE, S_MEAS, S_WAIT};
  assign expired = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = expired ? cnt_q : cnt_q - 32'd1;
    win_d   = win_q;
    cyc_d   = (active && cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
    // abort outranks both the ack and any counter expiry
    if (active && abort) begin
      state_d = S_FAIL;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state_d = S_RESET;
            cnt_d   = RST_LD;
            win_d   = '0;
            cyc_d   = '0;
          end
        end
        S_RESET: begin
          if (expired) begin
            state_d = S_SETTLE;
            cnt_d   = SET_LD;
          end
        end
        S_SETTLE: begin
          if (expired) begin
            state_d = S_MEAS;
            cnt_d   = MEAS_LD;
          end
        end
        S_MEAS: begin
          if (expired) begin
            state_d = S_WAIT;
            cnt_d   = ACK_LD;
          end
        end
        S_WAIT: begin
          if (chk_ack && chk_pass && win_q == LAST_W) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else if (chk_ack && chk_pass) begin
            state_d = S_MEAS;
            cnt_d   = MEAS_LD;
            win_d   = win_q + 8'd1;
          end else if (chk_ack || expired) begin
            state_d = S_FAIL;
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge virclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      win_q     <= '0;
      cyc_q     <= '0;
      dut_rst   <= 1'b1;
      meas_en   <= 1'b0;
      win_start <= 1'b0;
      chk_req   <= 1'b0;
      busy      <= 1'b0;
      finish    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      cyc_q     <= cyc_d;
      dut_rst   <= state_d inside {S_IDLE, S_RESET, S_FAIL};
      meas_en   <= (state_d == S_MEAS);
      win_start <= (state_d == S_MEAS) && (state_q != S_MEAS);
      chk_req   <= (state_d == S_WAIT);
      busy      <= state_d inside {S_RESET, S_SETTLE, S_MEAS, S_WAIT};
      finish    <= state_d inside {S_DONE, S_FAIL};
      fail      <= (state_d == S_FAIL);
    end
  end

  assign win_idx   = win_q;
  assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_test_phase_sequencer.sv
// Scoreboard bench: a run-level timeline model predicts phase events,
// a negedge monitor pops and checks them as the sequencer emits them.
module tb_test_phase_sequencer;

  localparam int RST  = 4;
  localparam int SET  = 16;
  localparam int MEAS = 32;
  localparam int NW   = 4;
  localparam int ACK  = 64;
  localparam int CW   = 16;
  localparam int CWS  = 4;
  localparam int NOAB = 32'h3fffffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic chk_ack = 1'b0;
  logic chk_pass = 1'b0;

  logic          dut_rst, meas_en, win_start, chk_req;
  logic          busy, finish, fail;
  logic [7:0]    win_idx;
  logic [CW-1:0] cycle_cnt;

  logic           s_dut_rst, s_meas_en, s_win_start, s_chk_req;
  logic           s_busy, s_finish, s_fail;
  logic [7:0]     s_win_idx;
  logic [CWS-1:0] s_cycle_cnt;

  test_phase_sequencer #(
    .RST_CYCLES(RST), .SETTLE_CYCLES(SET), .MEAS_CYCLES(MEAS),
    .N_WINDOWS(NW), .ACK_TIMEOUT(ACK), .CW(CW)
  ) dut (
    .virclk(clk), .rst(rst), .start(start), .abort(abort),
    .chk_ack(chk_ack), .chk_pass(chk_pass),
    .dut_rst(dut_rst), .meas_en(meas_en), .win_start(win_start),
    .win_idx(win_idx), .chk_req(chk_req), .busy(busy),
    .finish(finish), .fail(fail), .cycle_cnt(cycle_cnt)
  );

  test_phase_sequencer #(
    .RST_CYCLES(RST), .SETTLE_CYCLES(SET), .MEAS_CYCLES(MEAS),
    .N_WINDOWS(NW), .ACK_TIMEOUT(ACK), .CW(CWS)
  ) dut_sat (
    .virclk(clk), .rst(rst), .start(start), .abort(abort),
    .chk_ack(chk_ack), .chk_pass(chk_pass),
    .dut_rst(s_dut_rst), .meas_en(s_meas_en), .win_start(s_win_start),
    .win_idx(s_win_idx), .chk_req(s_chk_req), .busy(s_busy),
    .finish(s_finish), .fail(s_fail), .cycle_cnt(s_cycle_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {E_START, E_REL, E_WIN, E_FIN} kind_t;
  typedef struct {
    kind_t k;
    int    t;
    int    w;
    int    fl;
    int    cnt;
  } ev_t;

  ev_t q[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;
  int  pl[NW];
  bit  pp[NW];

  function automatic void chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic bit pop(kind_t k, output ev_t e);
    n_vec++;
    e = '{k: E_START, t: 0, w: 0, fl: 0, cnt: 0};
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL event_unexpected: got kind %0d, expected none (cycle %0d)",
               int'(k), cyc);
      return 1'b0;
    end
    e = q.pop_front();
    if (e.k != k) begin
      n_err++;
      $display("FAIL event_order: got kind %0d, expected kind %0d (cycle %0d)",
               int'(k), int'(e.k), cyc);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void push(kind_t k, int t, int w, int fl, int cnt);
    ev_t e;
    e = '{k: k, t: t, w: w, fl: fl, cnt: cnt};
    q.push_back(e);
  endfunction

  // Timeline of one run from its phase lengths, ack latencies and abort.
  // t is the first busy cycle; ab is the cycle abort is presented.
  function automatic void model(int t, int ab);
    int fin, fl, wi, s, req, last;
    fin = 0;
    fl  = 1;
    wi  = 0;
    push(E_START, t, 0, 0, 0);
    if (ab < t + RST) begin
      fin = ab + 1;
    end else begin
      push(E_REL, t + RST, 0, 0, 0);
      if (ab < t + RST + SET) begin
        fin = ab + 1;
      end else begin
        s = t + RST + SET;
        for (int w = 0; w < NW; w++) begin
          push(E_WIN, s, w, 0, 0);
          req  = s + MEAS;
          wi   = w;
          last = (pl[w] < ACK) ? req + pl[w] : req + ACK - 1;
          if (ab <= last) begin
            fin = ab + 1;
            break;
          end
          if (pl[w] >= ACK || !pp[w] || w == NW - 1) begin
            fin = last + 1;
            fl  = (pl[w] < ACK && pp[w]) ? 0 : 1;
            break;
          end
          s = last + 1;
        end
      end
    end
    push(E_FIN, fin, wi, fl, fin - t);
  endfunction

  logic p_busy = 1'b0;
  logic p_drst = 1'b1;
  logic p_fin  = 1'b0;

  always @(negedge clk) begin : mon
    ev_t e;
    if (mon_en && !rst) begin
      chk("meas_req_excl", int'(meas_en & chk_req), 0);
      if (busy && !p_busy && pop(E_START, e)) begin
        chk("start_time", cyc, e.t);
        chk("start_cnt", int'(cycle_cnt), 0);
        chk("start_finish", int'(finish), 0);
        chk("start_fail", int'(fail), 0);
        chk("start_win", int'(win_idx), 0);
        chk("start_dut_rst", int'(dut_rst), 1);
      end
      if (!dut_rst && p_drst && pop(E_REL, e))
        chk("rst_release_time", cyc, e.t);
      if (win_start && pop(E_WIN, e)) begin
        chk("win_time", cyc, e.t);
        chk("win_idx", int'(win_idx), e.w);
        chk("win_meas_en", int'(meas_en), 1);
      end
      if (finish && !p_fin && pop(E_FIN, e)) begin
        chk("fin_time", cyc, e.t);
        chk("fin_fail", int'(fail), e.fl);
        chk("fin_win", int'(win_idx), e.w);
        chk("fin_cnt", int'(cycle_cnt), e.cnt);
        chk("fin_dut_rst", int'(dut_rst), e.fl);
        chk("fin_meas_en", int'(meas_en), 0);
        chk("fin_chk_req", int'(chk_req), 0);
        chk("fin_busy", int'(busy), 0);
        chk("sat_cnt", int'(s_cycle_cnt), (e.cnt > 15) ? 15 : e.cnt);
        chk("sat_fail", int'(s_fail), e.fl);
        chk("sat_finish", int'(s_finish), 1);
      end
    end
    p_busy <= busy;
    p_drst <= dut_rst;
    p_fin  <= finish;
  end

  function automatic void set_nom();
    for (int w = 0; w < NW; w++) begin
      pl[w] = 0;
      pp[w] = 1'b1;
    end
  endfunction

  task automatic run(int ab_off);
    int t, ab, w, rc;
    bit done;
    @(negedge clk);
    start    = 1'b1;
    abort    = ($urandom_range(0, 3) == 0);
    chk_ack  = 1'b0;
    chk_pass = 1'b0;
    t  = cyc + 1;
    ab = (ab_off == NOAB) ? NOAB : t + ab_off;
    model(t, ab);
    w    = 0;
    rc   = 0;
    done = 1'b0;
    for (int n = 0; n < 1500 && !done; n++) begin
      @(negedge clk);
      start    = 1'b0;
      abort    = 1'b0;
      chk_ack  = 1'b0;
      chk_pass = 1'b0;
      if (finish) begin
        done = 1'b1;
      end else begin
        abort = (cyc == ab);
        if (chk_req) begin
          if (w < NW && rc == pl[w]) begin
            chk_ack  = 1'b1;
            chk_pass = pp[w];
            w++;
            rc = 0;
          end else begin
            rc++;
          end
        end else begin
          rc       = 0;
          chk_ack  = ($urandom_range(0, 3) == 0);
          chk_pass = 1'($urandom_range(0, 1));
        end
        if (busy && $urandom_range(0, 7) == 0) start = 1'b1;
      end
    end
    chk("run_finished", int'(done), 1);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    chk("finish_sticky", int'(finish), 1);
    chk("events_drained", q.size(), 0);
    q.delete();
    if (!done) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic rst_mid();
    int n;
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!meas_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_meas", int'(meas_en), 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_meas_en", int'(meas_en), 0);
    chk("rst_dut_rst", int'(dut_rst), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_win_idx", int'(win_idx), 0);
    chk("rst_cycle_cnt", int'(cycle_cnt), 0);
    chk("rst_finish", int'(finish), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_dut_rst", int'(dut_rst), 1);
    chk("reset_meas_en", int'(meas_en), 0);
    chk("reset_win_start", int'(win_start), 0);
    chk("reset_win_idx", int'(win_idx), 0);
    chk("reset_chk_req", int'(chk_req), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_finish", int'(finish), 0);
    chk("reset_fail", int'(fail), 0);
    chk("reset_cycle_cnt", int'(cycle_cnt), 0);
    chk("reset_sat_cnt", int'(s_cycle_cnt), 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    set_nom(); run(NOAB);
    set_nom(); run(NOAB);
    set_nom(); pp[1] = 1'b0; run(NOAB);
    set_nom(); pl[0] = 200; run(NOAB);
    set_nom(); run(RST + SET + 2 * (MEAS + 1) + MEAS);
    set_nom(); run(RST + 3);
    set_nom(); pl[2] = ACK - 1; run(NOAB);
    rst_mid();
    set_nom(); run(NOAB);

    for (int i = 0; i < 25; i++) begin
      int r;
      for (int w = 0; w < NW; w++) begin
        r = $urandom_range(0, 19);
        if (r < 12)       pl[w] = 0;
        else if (r < 17)  pl[w] = $urandom_range(1, 5);
        else if (r == 17) pl[w] = ACK - 1;
        else              pl[w] = 200;
        pp[w] = ($urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 2) == 0) run($urandom_range(0, 400));
      else                           run(NOAB);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/test_phase_sequencer.md
# test_phase_sequencer

Synthesizable sequencer that drives a testbench DUT through a fixed run: DUT reset, settle, N measurement windows, and a checker handshake after each window. It then raises a sticky finish/fail status that the bench polls before `finish_sim`. It runs on the virtual test clock `virclk` and replaces hand-written `repeat_virclk` chains in test modules, so run phasing is cycle-exact and reusable across benches.

## Interface
- RST_CYCLES, 4: cycles `dut_rst` is held after start (≥1)
- SETTLE_CYCLES, 16: cycles between DUT reset release and first window (≥1)
- MEAS_CYCLES, 32: length of each measurement window (≥1)
- N_WINDOWS, 4: number of windows per run (1..256)
- ACK_TIMEOUT, 64: max cycles `chk_req` may wait for `chk_ack` (≥1)
- CW, 16: width of `cycle_cnt`

Ports:
- virclk  in  1  test clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin run; sampled in IDLE, DONE, FAIL only
- abort  in  1  force FAIL from any active state
- chk_ack  in  1  checker acknowledges window result
- chk_pass  in  1  window result, valid when `chk_ack`=1
- dut_rst  out  1  reset to DUT
- meas_en  out  1  high during measurement windows
- win_start  out  1  one-cycle pulse on first cycle of each window
- win_idx  out  8  current window index
- chk_req  out  1  request checker verdict for window `win_idx`
- busy  out  1  run in progress
- finish  out  1  sticky: run ended (pass or fail)
- fail  out  1  sticky: run ended in failure
- cycle_cnt  out  CW  virclk cycles spent busy, saturating

## Operation
- States: IDLE, RESET, SETTLE, MEAS, WAIT_ACK, DONE, FAIL. One down-counter is loaded on every state entry.
- Reset values: state=IDLE, dut_rst=1, all other outputs 0, win_idx=0, cycle_cnt=0.
- IDLE: dut_rst=1. On start, go to RESET. Clear win_idx and cycle_cnt.
- RESET: dut_rst=1, busy=1, for exactly RST_CYCLES cycles, then SETTLE.
- SETTLE: dut_rst=0, for exactly SETTLE_CYCLES cycles, then MEAS.
- MEAS: meas_en=1 for exactly MEAS_CYCLES cycles. win_start=1 on the first of those cycles. Then WAIT_ACK.
- WAIT_ACK: chk_req=1 until ack.
  - chk_ack with chk_pass=1 and win_idx=N_WINDOWS-1: go to DONE.
  - chk_ack with chk_pass=1 otherwise: win_idx+1, go to MEAS.
  - chk_ack with chk_pass=0: go to FAIL.
  - ACK_TIMEOUT cycles with no ack: go to FAIL.
- DONE: finish=1, busy=0, dut_rst=0, win_idx holds.
- FAIL: finish=1, fail=1, busy=0, dut_rst=1, meas_en=0, chk_req=0.
- abort in RESET, SETTLE, MEAS or WAIT_ACK: go to FAIL next cycle. abort has priority over chk_ack and counter expiry. abort in IDLE, DONE or FAIL is ignored.
- start in DONE/FAIL: clear finish, fail, win_idx and cycle_cnt, go to RESET. start in active states is ignored.
- cycle_cnt increments every cycle busy=1 and saturates at 2^CW-1 (no wrap).
- chk_ack outside WAIT_ACK is ignored.

## Timing
- All outputs are registered and change only on virclk rising edge or on rst.
- start=1 sampled at edge t: busy=1 from t+1. dut_rst stays 1 through t+RST_CYCLES and falls at t+RST_CYCLES+1.
- First meas_en=1 cycle is t+RST_CYCLES+SETTLE_CYCLES+1. win_start coincides with it.
- chk_req rises the cycle after the last meas_en cycle. meas_en and chk_req are never both 1.
- chk_ack sampled at edge a: chk_req=0 from a+1. The next window's meas_en=1 and win_start=1 are also at a+1, giving zero idle cycles between windows.
- Timeout: if no ack on ACK_TIMEOUT consecutive chk_req cycles, fail=1 on the following cycle.
- Run length with immediate acks: RST_CYCLES + SETTLE_CYCLES + N_WINDOWS×(MEAS_CYCLES+1) cycles of busy.
- rst mid-run: all outputs return to reset values immediately (asynchronous). No state survives.

## Test plan
- Nominal run with defaults, ack+pass one cycle after each chk_req:
  - dut_rst=1 for 4 cycles after start.
  - 4 win_start pulses, 32 meas_en cycles each.
  - finish=1, fail=0, win_idx=3.
  - cycle_cnt=4+16+4×33=152.
- Fail verdict: chk_pass=0 on window 1 -> fail=1, finish=1, win_idx=1, no further meas_en, dut_rst=1.
- Timeout: never ack -> fail=1 exactly 64 cycles after chk_req rises. chk_req=0 thereafter.
- Abort/ack collision: abort and chk_ack+pass on the same cycle in WAIT_ACK -> FAIL, win_idx unchanged. Also assert abort during SETTLE -> FAIL next cycle.
- Restart and reset: start in DONE clears finish and cycle_cnt and repeats the nominal sequence. rst during MEAS -> meas_en=0 and dut_rst=1 immediately, state IDLE. start while busy is ignored (timing unchanged).
- Saturation: CW=4, defaults -> cycle_cnt holds at 15, never wraps to 0.
